// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and widths for the RAM write arbiter.
package ram_arb_pkg;
    localparam int RAM_ADDR_W = 17;
    localparam int RAM_DATA_W = 36;
    localparam int DROP_CNT_W = 8;
    typedef enum logic [1:0] {IDLE, WR_BRIDGE, WR_ENG} arb_state_e;
    typedef enum logic {GR_BRIDGE, GR_ENG} grant_e;
    typedef struct packed {
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] data;
    } ram_wr_t;
endpackage

// File: rtl/ram_arb_fifo.sv
// ram_arb_fifo: synchronous FIFO of bridge write frames; push and pop together when full is legal.
module ram_arb_fifo
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk_in,
    input  logic    rst_n_in,
    input  logic    push,
    input  logic    pop,
    input  ram_wr_t din,
    output ram_wr_t dout,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);
    ram_wr_t mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    // Extra pointer bit tells full from empty when the indices match.
    assign dout  = mem_q[rd_q[AW-1:0]];
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_q[AW-1:0]] <= din;
    end
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (pop) rd_q <= rd_q + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter: round-robin share of the RAM write port between the UART bridge and the engine.
// Define RAM_WR_ADDR_CHECK_EN to reject bridge frames whose address exceeds MEM_ADDR_W bits.
module ram_write_arbiter
    import ram_arb_pkg::*;
#(
    parameter int MEM_ADDR_W = RAM_ADDR_W,
    parameter int DATA_W     = RAM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [31:0]           bridge_addr_in,
    input  logic [DATA_W-1:0]     bridge_data_in,
    input  logic                  bridge_valid_in,
    input  logic [MEM_ADDR_W-1:0] eng_addr_in,
    input  logic [DATA_W-1:0]     eng_data_in,
    input  logic                  eng_valid_in,
    output logic                  eng_ready_out,
    output logic [MEM_ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0]     mem_data_out,
    output logic                  mem_we_out,
    input  logic                  mem_ready_in,
    output logic                  fifo_full_out,
    output logic [7:0]            drop_count_out
);
    arb_state_e state_q;
    grant_e last_q;
    ram_wr_t wr_q, fifo_dout;
    logic we_q, fifo_full, fifo_empty, push, pop, addr_ok, eng_win, drop;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
`ifdef RAM_WR_ADDR_CHECK_EN
    assign addr_ok = bridge_addr_in[31:MEM_ADDR_W] == '0;
`else
    logic unused_hi;
    assign unused_hi = ^bridge_addr_in[31:MEM_ADDR_W];
    assign addr_ok = 1'b1;
`endif
    // Engine wins in IDLE unless the bridge is pending and the engine had the last grant.
    assign eng_win = rst_n_in && state_q == IDLE && eng_valid_in && (fifo_empty || last_q == GR_BRIDGE);
    assign pop     = rst_n_in && state_q == IDLE && !fifo_empty && !eng_win;
    assign push    = bridge_valid_in && addr_ok && (!fifo_full || pop);
    assign drop    = bridge_valid_in && !push;
    assign drop_d  = (drop && drop_q != '1) ? drop_q + DROP_CNT_W'(1) : drop_q;
    ram_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .push    (push),
        .pop     (pop),
        .din     ('{addr: bridge_addr_in[MEM_ADDR_W-1:0], data: bridge_data_in}),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            last_q  <= GR_ENG;
            wr_q    <= '0;
            we_q    <= 1'b0;
            drop_q  <= '0;
        end else begin
            drop_q <= drop_d;
            if (eng_win) begin
                wr_q    <= '{addr: eng_addr_in, data: eng_data_in};
                we_q    <= 1'b1;
                state_q <= WR_ENG;
            end else if (pop) begin
                wr_q    <= fifo_dout;
                we_q    <= 1'b1;
                state_q <= WR_BRIDGE;
            end else if (state_q != IDLE && mem_ready_in) begin
                we_q    <= 1'b0;
                last_q  <= state_q == WR_ENG ? GR_ENG : GR_BRIDGE;
                state_q <= IDLE;
            end
        end
    end
    assign eng_ready_out  = eng_win;
    assign mem_addr_out   = wr_q.addr;
    assign mem_data_out   = wr_q.data;
    assign mem_we_out     = we_q;
    assign fifo_full_out  = fifo_full;
    assign drop_count_out = drop_q;
endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb_ram_write_arbiter: directed self-checking bench for ram_write_arbiter.
module tb_ram_write_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [31:0] bridge_addr_in = '0;
    logic [35:0] bridge_data_in = '0;
    logic        bridge_valid_in = 1'b0;
    logic [16:0] eng_addr_in = '0;
    logic [35:0] eng_data_in = '0;
    logic        eng_valid_in = 1'b0;
    logic        eng_ready_out;
    logic [16:0] mem_addr_out;
    logic [35:0] mem_data_out;
    logic        mem_we_out;
    logic        mem_ready_in = 1'b0;
    logic        fifo_full_out;
    logic [7:0]  drop_count_out;
    int checks = 0;
    int errors = 0;
    int eng_acc = 0;
    logic [16:0] wa [$];
    logic [35:0] wd [$];

    ram_write_arbiter dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .bridge_addr_in(bridge_addr_in), .bridge_data_in(bridge_data_in), .bridge_valid_in(bridge_valid_in),
        .eng_addr_in(eng_addr_in), .eng_data_in(eng_data_in), .eng_valid_in(eng_valid_in),
        .eng_ready_out(eng_ready_out), .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .mem_we_out(mem_we_out), .mem_ready_in(mem_ready_in), .fifo_full_out(fifo_full_out),
        .drop_count_out(drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Record every completed RAM write and every engine handshake.
    always @(posedge clk_in) begin
        if (rst_n_in && mem_we_out && mem_ready_in) begin
            wa.push_back(mem_addr_out);
            wd.push_back(mem_data_out);
        end
        if (rst_n_in && eng_valid_in && eng_ready_out) eng_acc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        tick(2);
        rst_n_in = 1'b1;
    endtask

    task automatic pulse(input logic [31:0] a, input logic [35:0] d);
        bridge_addr_in = a;
        bridge_data_in = d;
        bridge_valid_in = 1'b1;
        tick();
        bridge_valid_in = 1'b0;
    endtask

    task automatic wait_eng();
        int c0 = eng_acc;
        for (int i = 0; i < 30 && eng_acc == c0; i++) tick();
        check("eng_accept", 64'(eng_acc != c0), 1);
    endtask

    task automatic check_wr(input int i, input logic [16:0] a, input logic [35:0] d);
        check($sformatf("wr%0d_addr", i), i < wa.size() ? 64'(wa[i]) : 64'hx, 64'(a));
        check($sformatf("wr%0d_data", i), i < wd.size() ? 64'(wd[i]) : 64'hx, 64'(d));
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_we", 64'(mem_we_out), 0);
        check("rst_addr", 64'(mem_addr_out), 0);
        check("rst_data", 64'(mem_data_out), 0);
        check("rst_full", 64'(fifo_full_out), 0);
        check("rst_drop", 64'(drop_count_out), 0);
        check("rst_eng_ready", 64'(eng_ready_out), 0);
        rst_n_in = 1'b1;

        // 1: single bridge frame, write held until mem_ready_in
        wa.delete(); wd.delete();
        pulse(32'h10, 36'hABC);
        check("t1_we_latency", 64'(mem_we_out), 0);
        tick();
        check("t1_we", 64'(mem_we_out), 1);
        check("t1_addr", 64'(mem_addr_out), 64'h10);
        check("t1_data", 64'(mem_data_out), 64'hABC);
        mem_ready_in = 1'b1;
        tick();
        check("t1_we_off", 64'(mem_we_out), 0);
        check("t1_nwr", 64'(wa.size()), 1);

        // 2: two bridge frames vs engine: BRIDGE, ENG, BRIDGE
        do_reset();
        wa.delete(); wd.delete();
        pulse(32'h31, 36'h1);
        bridge_addr_in = 32'h32; bridge_data_in = 36'h2; bridge_valid_in = 1'b1;
        eng_addr_in = 17'h20; eng_data_in = 36'h5; eng_valid_in = 1'b1;
        #1;
        check("t2_eng_ready_bridge_wins", 64'(eng_ready_out), 0);
        tick();
        bridge_valid_in = 1'b0;
        wait_eng();
        eng_valid_in = 1'b0;
        tick(6);
        check("t2_nwr", 64'(wa.size()), 3);
        check_wr(0, 17'h31, 36'h1);
        check_wr(1, 17'h20, 36'h5);
        check_wr(2, 17'h32, 36'h2);

        // 3: stall 10 cycles mid-write with the engine still requesting
        wa.delete(); wd.delete();
        mem_ready_in = 1'b0;
        eng_addr_in = 17'h1ABCD; eng_data_in = 36'h123456789; eng_valid_in = 1'b1;
        wait_eng();
        eng_addr_in = 17'h00777; eng_data_in = 36'h2;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t3_we", 64'(mem_we_out), 1);
            check("t3_addr", 64'(mem_addr_out), 64'h1ABCD);
            check("t3_data", 64'(mem_data_out), 64'h123456789);
            check("t3_eng_ready", 64'(eng_ready_out), 0);
            tick();
        end
        mem_ready_in = 1'b1;
        wait_eng();
        eng_valid_in = 1'b0;
        tick(3);
        check("t3_nwr", 64'(wa.size()), 2);
        check_wr(0, 17'h1ABCD, 36'h123456789);
        check_wr(1, 17'h00777, 36'h2);

        // 4: port held by engine, 6 bridge pulses -> 4 queued, 2 dropped
        wa.delete(); wd.delete();
        mem_ready_in = 1'b0;
        eng_addr_in = 17'h50; eng_data_in = 36'h50; eng_valid_in = 1'b1;
        wait_eng();
        eng_valid_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulse(32'h40 + i, 36'h100 + i);
            if (i == 2) check("t4_not_full", 64'(fifo_full_out), 0);
            if (i == 3) check("t4_full", 64'(fifo_full_out), 1);
        end
        check("t4_drop", 64'(drop_count_out), 2);
        mem_ready_in = 1'b1;
        tick(14);
        check("t4_nwr", 64'(wa.size()), 5);
        check_wr(0, 17'h50, 36'h50);
        for (int i = 0; i < 4; i++) check_wr(i + 1, 17'h40 + 17'(i), 36'h100 + 36'(i));
        check("t4_drained", 64'(fifo_full_out), 0);

        // 5: bridge address above MEM_ADDR_W
        wa.delete(); wd.delete();
        pulse(32'h0002_0000, 36'h55);
        tick(4);
`ifdef RAM_WR_ADDR_CHECK_EN
        check("t5_drop", 64'(drop_count_out), 3);
        check("t5_nwr", 64'(wa.size()), 0);
`else
        check("t5_drop", 64'(drop_count_out), 2);
        check("t5_nwr", 64'(wa.size()), 1);
        check_wr(0, 17'h0, 36'h55);
`endif

        // 6: drop counter saturation, then reset during WR_ENG
        wa.delete(); wd.delete();
        mem_ready_in = 1'b0;
        eng_addr_in = 17'h66; eng_data_in = 36'h66; eng_valid_in = 1'b1;
        wait_eng();
        eng_valid_in = 1'b0;
        for (int i = 0; i < 300; i++) pulse(32'h60, 36'h60);
        check("t6_full", 64'(fifo_full_out), 1);
        check("t6_drop_sat", 64'(drop_count_out), 255);
        check("t6_we_busy", 64'(mem_we_out), 1);
        rst_n_in = 1'b0;
        tick();
        check("t6_rst_we", 64'(mem_we_out), 0);
        check("t6_rst_addr", 64'(mem_addr_out), 0);
        check("t6_rst_full", 64'(fifo_full_out), 0);
        check("t6_rst_drop", 64'(drop_count_out), 0);
        rst_n_in = 1'b1;
        mem_ready_in = 1'b1;
        tick(5);
        check("t6_no_stale_wr", 64'(wa.size()), 0);
        eng_valid_in = 1'b1;
        #1;
        check("t6_eng_ready_idle", 64'(eng_ready_out), 1);
        tick();
        eng_valid_in = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
